lenet_frame_reader: RTL and testbench
=====================================

Name: lenet_frame_reader

Overview:
- Consumer side of the LeNet input buffer that the camera preprocessing core fills.
- After the core's data_ready pulse, scans the 32x32 padded buffer (28x28 image at offset 2 rows / 2 cols) in raster order and streams the pixels to the LeNet engine over a valid/ready interface.
- Hides the buffer's 1-cycle synchronous read latency with a 2-entry output buffer, so sustained throughput is 1 pixel/cycle under full backpressure tolerance.

Parameters:
- IMG_W, 32, padded frame width in pixels.
- IMG_H, 32, padded frame height in pixels.
- PAD, 2, border width in pixels on every side.
- ADDR_W, 10, buffer address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.
- DATA_W, 8, pixel width.

Ports:
- clk25  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_ready  in  1  single-cycle pulse: buffer holds a complete frame.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address; valid when rd_en=1.
- rd_data  in  DATA_W  buffer read data, valid exactly 1 cycle after rd_en.
- m_valid  out  1  stream pixel valid.
- m_ready  in  1  stream sink ready.
- m_data  out  DATA_W  stream pixel.
- m_last  out  1  marks the final pixel of the frame (index IMG_W*IMG_H-1).
- busy  out  1  frame transfer in progress.
- frame_done  out  1  1-cycle pulse after the last handshake.
- overrun  out  1  1-cycle pulse: data_ready arrived while busy.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, frame_done=0, overrun=0. Reset mid-frame aborts the frame, empties the buffer, drops the in-flight read, and returns to IDLE.
- States:
  - IDLE: waits for data_ready. On data_ready go to STREAM, busy=1, rd_addr=0.
  - STREAM: issues reads for addresses 0..IMG_W*IMG_H-1 in order. rd_en=1 only when (buffered entries + in-flight read) < 2. rd_addr increments after each issued read. After address IMG_W*IMG_H-1 is issued, go to DRAIN.
  - DRAIN: no further reads. When the beat with m_last is handshaken (m_valid&m_ready), go to IDLE and pulse frame_done on the next cycle; busy drops on that same cycle.
- Latency: data_ready at cycle T gives rd_en at T+1 and the first m_valid at T+2. With m_ready held at 1, one beat per cycle, IMG_W*IMG_H beats total.
- Stream rules:
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - m_ready may toggle arbitrarily; no pixel is lost or duplicated.
- Output buffer: 2-entry FIFO. rd_data is written into it the cycle after rd_en. The head drives m_data. Pop and push in the same cycle are allowed. Overflow is impossible by the issue rule above.
- m_last=1 only on the head entry whose source address was IMG_W*IMG_H-1; the address is tagged at issue.
- Overrun:
  - data_ready while busy=1 is ignored (the frame continues) and overrun pulses the next cycle.
  - data_ready on the same cycle as the final handshake also counts as overrun.
  - data_ready on the frame_done cycle starts a new frame normally.
- Arithmetic: rd_addr wraps only via explicit reset to 0 at frame start; the row/col counters behind the border logic are clog2-sized and never overflow.

Optional Feature:
- Macro: LENET_BORDER_ZERO_EN.
- Defined:
  - Addresses with row<PAD, row>=IMG_H-PAD, col<PAD or col>=IMG_W-PAD are not read (rd_en stays 0 for them).
  - A zero entry enters the buffer with the same 1-cycle timing as a real read.
  - Stream timing and beat count are unchanged.
- Undefined: every address is read, and border pixels carry whatever the buffer holds.

Test Plan:
- Reset, then one data_ready with the buffer preloaded with mem[a]=a[7:0] and m_ready=1 -> 1024 beats on consecutive cycles starting T+2, m_data=0,1,..,255,0,..; m_last only on beat 1023; frame_done at final beat +1.
- Same frame with m_ready random 50% -> identical data sequence, no drop or duplicate; m_data stable during every stall; rd_en never issues with 2 entries buffered.
- Stall case: m_ready=0 for 20 cycles after the first valid -> at most 2 reads issued, m_data=0 held, then resumes at 1/cycle.
- data_ready pulsed at beat 500 -> overrun pulse, frame completes with 1024 beats; a second data_ready on the frame_done cycle -> a new full frame, no overrun.
- rst_n asserted at beat 300 -> all outputs 0 immediately; after release, a fresh data_ready streams from address 0.
- LENET_BORDER_ZERO_EN defined, buffer filled 0xFF -> beats at (row 0,col 5), (row 10,col 1), (row 31,col 31) are 0x00; (row 2,col 2) is 0xFF; rd_en count = 784.

Source files
------------

// File: rtl/lenet_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : lenet_frame_reader
// Description : Consumer side of the LeNet input buffer. After a data_ready
//               pulse it scans the IMG_W x IMG_H padded frame in raster order
//               and streams every pixel over a valid/ready interface. A
//               2-entry output buffer with a read-data bypass absorbs the
//               buffer's 1-cycle read latency, giving 1 pixel/cycle with full
//               backpressure tolerance.
// Optional    : LENET_BORDER_ZERO_EN - border pixels (PAD wide on each side)
//               are not read from the buffer; zeros are streamed instead with
//               identical timing.
// Ports       : clk25, rst_n (async, active-low)
//               data_ready            - frame available pulse
//               rd_en/rd_addr/rd_data - synchronous buffer read port
//               m_valid/m_ready/m_data/m_last - output pixel stream
//               busy, frame_done, overrun - status
// Revision    : 1.0 - initial release
// ============================================================================
module lenet_frame_reader #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int PAD    = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              data_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    logic [1:0]        state;
    logic [1:0]        count;       // entries held in the output buffer
    logic [DATA_W-1:0] buf0_data;   // head entry
    logic [DATA_W-1:0] buf1_data;
    logic              buf0_last;
    logic              buf1_last;
    logic              inflight;    // a pixel arrives on rd_data this cycle
    logic              inflight_last;
    logic              slot_free;
    logic              issue;       // one address slot is consumed this cycle
    logic              pop;
    logic [DATA_W-1:0] in_data;

`ifdef LENET_BORDER_ZERO_EN
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LO = COL_W'(PAD);
    localparam logic [COL_W-1:0] COL_HI = COL_W'(IMG_W - PAD);
    localparam logic [ROW_W-1:0] ROW_LO = ROW_W'(PAD);
    localparam logic [ROW_W-1:0] ROW_HI = ROW_W'(IMG_H - PAD);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             border;
    logic             inflight_zero;

    assign border  = (row < ROW_LO) || (row >= ROW_HI) ||
                     (col < COL_LO) || (col >= COL_HI);
    assign rd_en   = issue && !border;
    assign in_data = inflight_zero ? '0 : rd_data;
`else
    assign rd_en   = issue;
    assign in_data = rd_data;
`endif

    // Buffered entries plus the in-flight read never exceed two, so the
    // buffer cannot overflow however long m_ready stays low.
    assign slot_free = (count == 2'd0) || ((count == 2'd1) && !inflight);
    assign issue     = (state == S_STREAM) && slot_free;

    // With the buffer empty the arriving read data is presented directly,
    // which is what gives first valid one cycle after the first read.
    assign m_valid = (count != 2'd0) || inflight;
    assign m_data  = (count != 2'd0) ? buf0_data : (inflight ? in_data : '0);
    assign m_last  = (count != 2'd0) ? buf0_last : (inflight && inflight_last);
    assign pop     = m_valid && m_ready;
    assign busy    = (state != S_IDLE);

    // Read pipeline: tag each slot at issue time.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
`ifdef LENET_BORDER_ZERO_EN
            inflight_zero <= 1'b0;
`endif
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rd_addr == LAST_ADDR);
`ifdef LENET_BORDER_ZERO_EN
            inflight_zero <= issue && border;
`endif
        end
    end

    // Output buffer. A pop with an empty buffer consumes the bypassed
    // arrival, so nothing is stored in that case.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            buf0_data <= '0;
            buf1_data <= '0;
            buf0_last <= 1'b0;
            buf1_last <= 1'b0;
        end else begin
            case (count)
                2'd0: begin
                    if (inflight && !pop) begin
                        buf0_data <= in_data;
                        buf0_last <= inflight_last;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && inflight) begin
                        buf0_data <= in_data;
                        buf0_last <= inflight_last;
                    end else if (pop) begin
                        count <= 2'd0;
                    end else if (inflight) begin
                        buf1_data <= in_data;
                        buf1_last <= inflight_last;
                        count     <= 2'd2;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        buf0_data <= buf1_data;
                        buf0_last <= buf1_last;
                        if (inflight) begin
                            buf1_data <= in_data;
                            buf1_last <= inflight_last;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    // Frame control. rd_addr (and row/col) stop on the final address so
    // they never wrap; they are cleared only at frame start.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
`ifdef LENET_BORDER_ZERO_EN
            col        <= '0;
            row        <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            overrun    <= data_ready && busy;
            case (state)
                S_IDLE: begin
                    if (data_ready) begin
                        state   <= S_STREAM;
                        rd_addr <= '0;
`ifdef LENET_BORDER_ZERO_EN
                        col     <= '0;
                        row     <= '0;
`endif
                    end
                end
                S_STREAM: begin
                    if (issue) begin
                        if (rd_addr == LAST_ADDR) begin
                            state <= S_DRAIN;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
`ifdef LENET_BORDER_ZERO_EN
                            if (col == COL_W'(IMG_W - 1)) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
`endif
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && m_last) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lenet_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lenet_frame_reader
// Description : Self-checking bench for lenet_frame_reader. Frame starts push
//               the expected pixel sequence into a queue; a monitor pops and
//               compares on every handshake and checks stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lenet_frame_reader;

    localparam int N = 1024;
`ifdef LENET_BORDER_ZERO_EN
    localparam int READS = 784;
    localparam bit RDEN0 = 1'b0;
`else
    localparam int READS = 1024;
    localparam bit RDEN0 = 1'b1;
`endif

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_ready = 1'b0;
    logic       m_ready = 1'b0;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    logic [7:0] mem [N];
    logic [8:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_mode = 1;
    int frame_beats = 0, frame_reads = 0;
    int first_v_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
    int ovr_cnt = 0, t0 = 0;
    int issued = 0, popped = 0;
    bit stall_pend = 1'b0;
    logic [7:0] held_d;
    logic       held_l;

    lenet_frame_reader dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .data_ready (data_ready),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk25 = ~clk25;
    always @(posedge clk25) cyc <= cyc + 1;

    // Synchronous buffer model: data one cycle after rd_en.
    always @(posedge clk25) if (rd_en) rd_data <= mem[rd_addr];

    always @(posedge clk25) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int a);
`ifdef LENET_BORDER_ZERO_EN
        if ((a / 32) < 2 || (a / 32) >= 30 || (a % 32) < 2 || (a % 32) >= 30) return 8'h00;
`endif
        return mem[a];
    endfunction

    // Monitor / scoreboard
    always @(negedge clk25) begin
        logic [8:0] e;
        if (!rst_n) begin
            stall_pend = 1'b0;
            issued     = 0;
            popped     = 0;
        end else begin
            if (stall_pend) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, held_d);
                chk("stall_last", m_last, held_l);
            end
`ifndef LENET_BORDER_ZERO_EN
            if (rd_en) chk("rd_en_occupancy", (issued - popped) < 2, 1);
`endif
            if (rd_en) begin
                issued++;
                frame_reads++;
            end
            if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexpected: got data %0h, required no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e[7:0]);
                    chk("beat_last", m_last, e[8]);
                end
                popped++;
                frame_beats++;
                if (m_last) last_hs_cyc = cyc;
            end
            stall_pend = m_valid && !m_ready;
            held_d     = m_data;
            held_l     = m_last;
            if (frame_done) done_cyc = cyc;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // Called at negedge+1; data_ready is high for the current cycle T.
    task automatic start_frame();
        data_ready = 1'b1;
        t0 = cyc;
        for (int a = 0; a < N; a++) exp_q.push_back({1'(a == N - 1), exp_pix(a)});
        frame_beats = 0;
        frame_reads = 0;
        first_v_cyc = -1;
        last_hs_cyc = -1;
        done_cyc    = -1;
        @(posedge clk25); #1;
        data_ready = 1'b0;
        chk("rd_en_at_T1", rd_en, RDEN0);
        chk("rd_addr_at_T1", rd_addr, 0);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 5000 && frame_beats < n; i++) begin
            @(negedge clk25); #1;
        end
        chk("beats_reached", frame_beats >= n, 1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk25); #1;
            seen = frame_done;
        end
        chk("frame_done_seen", seen, 1);
    endtask

    initial begin
        for (int a = 0; a < N; a++) begin
`ifdef LENET_BORDER_ZERO_EN
            mem[a] = 8'hFF;
`else
            mem[a] = a[7:0];
`endif
        end

        // Reset state
        repeat (3) @(negedge clk25);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk25); #1;

        // Full frame, m_ready held high
        start_frame();
        wait_done(3000);
        chk("first_valid_T2", first_v_cyc, t0 + 2);
        chk("last_beat_cycle", last_hs_cyc, t0 + 1025);
        chk("done_after_last", done_cyc, last_hs_cyc + 1);
        chk("beats_f1", frame_beats, N);
        chk("reads_f1", frame_reads, READS);
        chk("no_overrun_f1", ovr_cnt, 0);
        @(negedge clk25); #1;
        chk("done_one_cycle", frame_done, 0);
        chk("busy_after_done", busy, 0);

        // Random backpressure
        ready_mode = 2;
        start_frame();
        wait_done(8000);
        chk("beats_rand", frame_beats, N);
        chk("reads_rand", frame_reads, READS);
        chk("queue_empty_rand", exp_q.size(), 0);

        // Long stall right after first valid
        ready_mode = 0;
        repeat (2) @(negedge clk25);
        #1;
        start_frame();
        for (int i = 0; i < 10 && !m_valid; i++) begin
            @(negedge clk25); #1;
        end
        chk("stall_first_valid_T2", first_v_cyc, t0 + 2);
        repeat (20) @(negedge clk25);
        #1;
        chk("stall_reads_le2", frame_reads <= 2, 1);
        chk("stall_hold_data0", m_data, 8'h00);
        chk("stall_hold_valid", m_valid, 1);
        ready_mode = 1;
        wait_done(3000);
        chk("beats_stall", frame_beats, N);
        chk("reads_stall", frame_reads, READS);

        // data_ready during a frame, then on the frame_done cycle
        start_frame();
        wait_beats(500);
        data_ready = 1'b1;
        @(posedge clk25); #1;
        data_ready = 1'b0;
        chk("overrun_pulse", overrun, 1);
        chk("busy_during_overrun", busy, 1);
        wait_done(3000);
        chk("beats_overrun", frame_beats, N);
        chk("overrun_count", ovr_cnt, 1);
        chk("busy_on_done", busy, 0);
        start_frame();
        wait_done(3000);
        chk("first_valid_backtoback", first_v_cyc, t0 + 2);
        chk("beats_backtoback", frame_beats, N);
        chk("no_overrun_on_done", ovr_cnt, 1);

        // Reset mid-frame
        start_frame();
        wait_beats(300);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk25);
        rst_n = 1'b1;
        @(negedge clk25); #1;
        start_frame();
        wait_done(3000);
        chk("beats_after_reset", frame_beats, N);
        chk("reads_after_reset", frame_reads, READS);
        chk("queue_empty_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
